// File: rtl/fullsub_pkg.sv
// Shared definitions for the fullsub registered subtractor.
// Holds the default operand width and the single-bit subtract-with-borrow
// function used by the bit cell.
package fullsub_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Returns {borrow, diff} for one bit position: x - y - c.
    function automatic logic [1:0] fs_bit(input logic x, input logic y, input logic c);
        logic diff;
        logic borrow;
        diff   = x ^ y ^ c;
        borrow = (~x & y) | (~x & c) | (y & c);
        return {borrow, diff};
    endfunction

endpackage

// File: rtl/fullsub_bit.sv
// Combinational one-bit full subtractor cell: d = x - y - bin, bout = borrow.
module fullsub_bit
    import fullsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic [1:0] res;

    assign res  = fs_bit(x, y, bin);
    assign d    = res[0];
    assign bout = res[1];

endmodule

// File: rtl/fullsub.sv
// Registered ripple-borrow full subtractor: d = (x - y - z) mod 2^WIDTH,
// b = final borrow. One result per cycle, one cycle of latency.
//
// Interface: in_valid qualifies x/y/z on a rising clk edge; there is no ready,
// the block accepts every valid beat. out_valid is high for exactly the cycle
// after an accepted beat; when it is low, d/b (and ov) hold the last result.
//
// Optional feature: define FULLSUB_OVERFLOW_EN to add the registered signed
// overflow output ov.
module fullsub
    import fullsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             z,
    output logic [WIDTH-1:0] d,
    output logic             b,
`ifdef FULLSUB_OVERFLOW_EN
    output logic             ov,
`endif
    output logic             out_valid
);

    // Borrow chain: c[0] is the borrow-in, c[WIDTH] the borrow-out.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] diff_w;

    assign c[0] = z;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fullsub_bit u_bit (
            .x    (x[i]),
            .y    (y[i]),
            .bin  (c[i]),
            .d    (diff_w[i]),
            .bout (c[i+1])
        );
    end

`ifdef FULLSUB_OVERFLOW_EN
    // Signed overflow is the borrow into the sign bit differing from the
    // borrow out of it; for WIDTH=1 the borrow into the sign bit is z.
    logic ov_w;
    assign ov_w = c[WIDTH] ^ c[WIDTH-1];

    // Overflow flag register, captured alongside the difference.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ov <= 1'b0;
        end else if (in_valid) begin
            ov <= ov_w;
        end
    end
`endif

    // Result register: reset clears, valid beats load, otherwise hold so that
    // undefined operands during idle cycles never reach the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d         <= '0;
            b         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                d <= diff_w;
                b <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_fullsub.sv
// Self-checking bench for fullsub at WIDTH=1, 4 and 8.
// Optional feature FULLSUB_OVERFLOW_EN: when defined the ov outputs are checked.
module tb_fullsub;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic       v1, z1, v4, z4, v8, z8;
    logic [0:0] x1, y1, d1;
    logic [3:0] x4, y4, d4;
    logic [7:0] x8, y8, d8;
    logic       b1, b4, b8, ov1_unused, ov4_unused, ov8_unused;
    logic       o1, o4, o8;
`ifdef FULLSUB_OVERFLOW_EN
    logic       ov1, ov4, ov8;
`endif

    int checks = 0;
    int failures = 0;

    fullsub #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .x(x1), .y(y1), .z(z1),
        .d(d1), .b(b1),
`ifdef FULLSUB_OVERFLOW_EN
        .ov(ov1),
`endif
        .out_valid(o1));

    fullsub #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .x(x4), .y(y4), .z(z4),
        .d(d4), .b(b4),
`ifdef FULLSUB_OVERFLOW_EN
        .ov(ov4),
`endif
        .out_valid(o4));

    fullsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .x(x8), .y(y8), .z(z8),
        .d(d8), .b(b8),
`ifdef FULLSUB_OVERFLOW_EN
        .ov(ov8),
`endif
        .out_valid(o8));

    assign ov1_unused = 1'b0;
    assign ov4_unused = 1'b0;
    assign ov8_unused = 1'b0;

    // ---------------- reference model ----------------
    // Plain integer arithmetic: returns {ov, b, d[7:0]} for width w.
    function automatic logic [9:0] model(input int w, input int xv, input int yv, input int zv);
        int r, sx, sy, sr, lim;
        logic [7:0] dd;
        logic bb, oo;
        r   = xv - yv - zv;
        dd  = 8'(r & ((1 << w) - 1));
        bb  = (r < 0);
        lim = 1 << (w - 1);
        sx  = (xv >= lim) ? xv - (1 << w) : xv;
        sy  = (yv >= lim) ? yv - (1 << w) : yv;
        sr  = sx - sy - zv;
        oo  = (sr < -lim) || (sr > lim - 1);
        return {oo, bb, dd};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        x1 = '0; y1 = '0; z1 = 1'b0;
        x4 = '0; y4 = '0; z4 = 1'b0;
        x8 = '0; y8 = '0; z8 = 1'b0;
    endtask

    // ---------------- scoreboard queue ----------------
    logic [9:0] exp_q[$];

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_all();
        rst_n = 1'b0;
        v1 = 1'b1; x1 = 1'b1; y1 = 1'b0; z1 = 1'b0;
        v4 = 1'b1; x4 = 4'd9; v8 = 1'b1; x8 = 8'd77;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (d1 !== 1'b0 || b1 !== 1'b0 || o1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_w1 cyc%0d: d=%b b=%b ov=%b, want 0 0 0", i, d1, b1, o1);
            end
            checks++;
            if (d4 !== 4'd0 || o4 !== 1'b0 || d8 !== 8'd0 || o8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_w4w8 cyc%0d: d4=%0d v4=%b d8=%0d v8=%b, want 0", i, d4, o4, d8, o8);
            end
`ifdef FULLSUB_OVERFLOW_EN
            checks++;
            if (ov1 !== 1'b0 || ov4 !== 1'b0 || ov8 !== 1'b0) begin
                failures++;
                $display("FAIL reset_ov cyc%0d: %b%b%b want 000", i, ov1, ov4, ov8);
            end
`endif
        end
        rst_n = 1'b1;
        v4 = 1'b0; v8 = 1'b0;
        tick();
        checks++;
        if (d1 !== 1'b1 || b1 !== 1'b0 || o1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: d=%b b=%b v=%b, want 1 0 1", d1, b1, o1);
        end
        idle_all();
    endtask

    task automatic test_exhaustive_w1();
        logic [7:0] exp_d = 8'b1001_0110; // bit i = expected d for {x,y,z}=i
        logic [7:0] exp_b = 8'b1000_1110;
        logic [2:0] idx;
        logic [9:0] m;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            v1 = 1'b1; x1 = idx[2]; y1 = idx[1]; z1 = idx[0];
            tick();
            checks++;
            if (d1 !== exp_d[i] || b1 !== exp_b[i] || o1 !== 1'b1) begin
                failures++;
                $display("FAIL w1_%b: d=%b b=%b v=%b, want %b %b 1", idx, d1, b1, o1, exp_d[i], exp_b[i]);
            end
            m = model(1, int'(idx[2]), int'(idx[1]), int'(idx[0]));
`ifdef FULLSUB_OVERFLOW_EN
            checks++;
            if (ov1 !== m[9]) begin
                failures++;
                $display("FAIL w1_ov_%b: ov=%b want %b", idx, ov1, m[9]);
            end
`else
            if (m[9] === 1'bx) $display("model produced x");
`endif
        end
        idle_all();
        tick();
    endtask

    task automatic test_hold();
        v1 = 1'b1; x1 = 1'b0; y1 = 1'b1; z1 = 1'b0;
        tick();
        checks++;
        if (d1 !== 1'b1 || b1 !== 1'b1 || o1 !== 1'b1) begin
            failures++;
            $display("FAIL hold_load: d=%b b=%b v=%b, want 1 1 1", d1, b1, o1);
        end
        for (int i = 0; i < 4; i++) begin
            v1 = 1'b0;
            if (i == 3) begin
                x1 = 1'bx; y1 = 1'bx; z1 = 1'bx;
            end else begin
                x1 = 1'b1; y1 = 1'b1; z1 = 1'b1;
            end
            tick();
            checks++;
            if (d1 !== 1'b1 || b1 !== 1'b1 || o1 !== 1'b0) begin
                failures++;
                $display("FAIL hold_cyc%0d: d=%b b=%b v=%b, want 1 1 0", i, d1, b1, o1);
            end
`ifdef FULLSUB_OVERFLOW_EN
            checks++;
            if (ov1 !== 1'b1) begin
                failures++;
                $display("FAIL hold_ov_cyc%0d: ov=%b want 1", i, ov1);
            end
`endif
        end
        idle_all();
    endtask

    task automatic test_width4();
        logic [3:0] tx[4] = '{4'd3, 4'd8, 4'd0, 4'd15};
        logic [3:0] ty[4] = '{4'd5, 4'd1, 4'd15, 4'd0};
        logic       tz[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] td[4] = '{4'd13, 4'd7, 4'd0, 4'd15};
        logic       tb[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       tov[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            v4 = 1'b1; x4 = tx[i]; y4 = ty[i]; z4 = tz[i];
            tick();
            checks++;
            if (d4 !== td[i] || b4 !== tb[i] || o4 !== 1'b1) begin
                failures++;
                $display("FAIL w4_%0d: d=%0d b=%b v=%b, want %0d %b 1", i, d4, b4, o4, td[i], tb[i]);
            end
`ifdef FULLSUB_OVERFLOW_EN
            checks++;
            if (ov4 !== tov[i]) begin
                failures++;
                $display("FAIL w4_ov_%0d: ov=%b want %b", i, ov4, tov[i]);
            end
`else
            if (tov[i] === 1'bx) $display("table has x");
`endif
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_midstream();
        logic [9:0] m;
        v8 = 1'b1; x8 = 8'd200; y8 = 8'd17; z8 = 1'b0;
        tick();
        checks++;
        if (d8 !== 8'd183 || b8 !== 1'b0 || o8 !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre: d=%0d b=%b v=%b, want 183 0 1", d8, b8, o8);
        end
        x8 = 8'd5; y8 = 8'd9; z8 = 1'b1; rst_n = 1'b0;
        tick();
        checks++;
        if (d8 !== 8'd0 || b8 !== 1'b0 || o8 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: d=%0d b=%b v=%b, want 0 0 0", d8, b8, o8);
        end
        rst_n = 1'b1;
        x8 = 8'd9; y8 = 8'd5; z8 = 1'b1;
        m = model(8, 9, 5, 1);
        tick();
        checks++;
        if (d8 !== m[7:0] || b8 !== m[8] || o8 !== 1'b1) begin
            failures++;
            $display("FAIL mid_after: d=%0d b=%b v=%b, want %0d %b 1", d8, b8, o8, m[7:0], m[8]);
        end
        idle_all();
    endtask

    task automatic test_random_w8();
        logic [9:0] last;
        logic [9:0] e;
        logic       vv;
        int         xv, yv, zv;
        last = '0;
        for (int i = 0; i < 1000; i++) begin
            vv = (i == 0) ? 1'b1 : 1'(($urandom_range(0, 3) != 0));
            xv = int'($urandom_range(0, 255));
            yv = int'($urandom_range(0, 255));
            zv = int'($urandom_range(0, 1));
            v8 = vv; x8 = 8'(xv); y8 = 8'(yv); z8 = 1'(zv);
            if (vv) exp_q.push_back(model(8, xv, yv, zv));
            tick();
            if (vv) begin
                if (exp_q.size() == 0) begin
                    e = last;
                end else begin
                    e = exp_q.pop_front();
                end
                last = e;
            end
            checks++;
            if (d8 !== last[7:0] || b8 !== last[8] || o8 !== vv) begin
                failures++;
                $display("FAIL rand_%0d: d=%0d b=%b v=%b, want %0d %b %b", i, d8, b8, o8, last[7:0], last[8], vv);
            end
`ifdef FULLSUB_OVERFLOW_EN
            checks++;
            if (ov8 !== last[9]) begin
                failures++;
                $display("FAIL rand_ov_%0d: ov=%b want %b", i, ov8, last[9]);
            end
`endif
        end
        idle_all();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        idle_all();
        #2;
        test_reset();
        test_exhaustive_w1();
        test_hold();
        test_width4();
        test_reset_midstream();
        test_random_w8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
